// File: rtl/multicycle_control.sv
// Multicycle main controller.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states.
// Every cycle it drives all datapath control strobes. It also handles the memory-ready
// handshake and counts IR loads.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   opcode            4-bit IR opcode (used in DECODE and MEM_ADDR)
//   zero              ALU zero flag (used in BRANCH)
//   mem_ready         memory access completes this cycle
//   ALUOP             00 add, 01 subtract, 10 use function code
//   alu_src_a/b       ALU operand selects
//   pc_write, pc_src  PC load enable and source select
//   ir_write, mem_read, mem_write, iord          IR load, memory strobes, address select
//   reg_write, reg_dst, mem_to_reg               register-file write controls
//   state             current state encoding (debug)
//   halted, illegal   sticky status flags
//   instr_count       IR loads since reset, wraps
module multicycle_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       ALUOP,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11,
        StHalt    = 4'd12,
        StIllegal = 4'd13
    } state_e;

    localparam logic [3:0] OpRType = 4'b0000;
    localparam logic [3:0] OpLw    = 4'b0001;
    localparam logic [3:0] OpSw    = 4'b0010;
    localparam logic [3:0] OpBeq   = 4'b0011;
    localparam logic [3:0] OpAddi  = 4'b0100;
    localparam logic [3:0] OpJ     = 4'b0101;
    localparam logic [3:0] OpHalt  = 4'b1111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             halted_q, illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            count_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_write) begin
                count_q <= count_q + CNT_W'(1);
            end
            // Flags rise together with the terminal state itself.
            if (state_d == StHalt) begin
                halted_q <= 1'b1;
            end
            if (state_d == StIllegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ALUOP      = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = 2'b11;
                case (opcode)
                    OpRType:     state_d = StExecR;
                    OpLw, OpSw:  state_d = StMemAddr;
                    OpBeq:       state_d = StBranch;
                    OpAddi:      state_d = StAddiEx;
                    OpJ:         state_d = StJump;
                    OpHalt:      state_d = StHalt;
                    default:     state_d = StIllegal;
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Only LW or SW reach this state; the IR is still stable.
                state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = 1'b1;
                ALUOP     = 2'b10;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                ALUOP     = 2'b01;
                pc_src    = 2'b01;
                pc_write  = zero;
                state_d   = StFetch;
            end
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StHalt:    state_d = StHalt;
            StIllegal: state_d = StIllegal;
            // Unused encodings are unreachable; park safely if ever entered.
            default:   state_d = StIllegal;
        endcase

        // Reset kills every strobe at once so an aborted write never lands.
        if (rst) begin
            ALUOP      = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

    assign state       = state_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (CNT_W=4 build so the counter wrap is reachable).
module tb_multicycle_control;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       opcode = 4'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic [1:0]       ALUOP;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write, mem_read, mem_write, iord;
    logic             reg_write, reg_dst, mem_to_reg;
    logic [3:0]       state;
    logic             halted, illegal;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int failures = 0;

    logic [14:0] ctrl;
    logic [4:0]  strobes;
    assign ctrl = {ALUOP, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, mem_read,
                   mem_write, iord, reg_write, reg_dst, mem_to_reg};
    assign strobes = {pc_write, ir_write, mem_read, mem_write, reg_write};

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .ALUOP(ALUOP), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .state(state), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = 4'd0; zero = 1'b0;
        tick(); tick();
        checks++; if (state !== 4'd0) begin failures++;
            $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (instr_count !== 4'd0) begin failures++;
            $display("FAIL reset_count got=%0d exp=0", instr_count); end
        checks++; if ({halted, illegal} !== 2'b00) begin failures++;
            $display("FAIL reset_flags got=%b exp=00", {halted, illegal}); end
        checks++; if (ctrl !== 15'd0) begin failures++;
            $display("FAIL reset_ctrl_forced got=%h exp=0", ctrl); end
        rst = 1'b0; mem_ready = 1'b0; #1;
        checks++; if ({mem_read, iord, alu_src_b, ir_write, pc_write} !== 6'b100100) begin
            failures++; $display("FAIL fetch_stall_strobes got=%b exp=100100",
            {mem_read, iord, alu_src_b, ir_write, pc_write}); end
        tick();
        checks++; if (state !== 4'd0 || instr_count !== 4'd0) begin failures++;
            $display("FAIL fetch_hold got=%0d/%0d exp=0/0", state, instr_count); end
        mem_ready = 1'b1; #1;
        checks++; if ({ir_write, pc_write, mem_read} !== 3'b111) begin failures++;
            $display("FAIL fetch_ready got=%b exp=111", {ir_write, pc_write, mem_read}); end
    endtask

    task automatic test_rtype();
        opcode = 4'b0000; mem_ready = 1'b1;
        tick();
        checks++; if (state !== 4'd1 || alu_src_b !== 2'b11 || ALUOP !== 2'b00) begin
            failures++; $display("FAIL r_decode got=%0d/%b exp=1/11", state, alu_src_b); end
        tick();
        checks++; if (state !== 4'd6 || ALUOP !== 2'b10 || alu_src_a !== 1'b1) begin
            failures++; $display("FAIL r_exec got=%0d/%b exp=6/10", state, ALUOP); end
        tick();
        checks++; if (state !== 4'd7 || {reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
            failures++; $display("FAIL r_wb got=%0d/%b exp=7/110", state,
            {reg_write, reg_dst, mem_to_reg}); end
        tick();
        checks++; if (state !== 4'd0 || instr_count !== 4'd1) begin failures++;
            $display("FAIL r_done got=%0d/%0d exp=0/1", state, instr_count); end
    endtask

    task automatic test_lw_stall();
        opcode = 4'b0001; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state !== 4'd2 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin
            failures++; $display("FAIL lw_addr got=%0d/%b exp=2/10", state, alu_src_b); end
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (state !== 4'd3 || {mem_read, iord} !== 2'b11) begin failures++;
                $display("FAIL lw_stall%0d got=%0d/%b exp=3/11", i, state, {mem_read, iord});
            end
            tick();
        end
        mem_ready = 1'b1; #1;
        checks++; if (state !== 4'd3 || {mem_read, iord} !== 2'b11) begin failures++;
            $display("FAIL lw_rd_last got=%0d exp=3", state); end
        tick();
        checks++; if (state !== 4'd4 || {reg_write, reg_dst, mem_to_reg} !== 3'b101) begin
            failures++; $display("FAIL lw_wb got=%0d/%b exp=4/101", state,
            {reg_write, reg_dst, mem_to_reg}); end
        tick();
        checks++; if (state !== 4'd0 || instr_count !== 4'd2) begin failures++;
            $display("FAIL lw_done got=%0d/%0d exp=0/2", state, instr_count); end
    endtask

    task automatic test_beq();
        logic z;
        for (int k = 0; k < 2; k++) begin
            z = (k == 0);
            opcode = 4'b0011; zero = z; mem_ready = 1'b1;
            tick(); tick(); #1;
            checks++; if (state !== 4'd8 || pc_write !== z || pc_src !== 2'b01 ||
                          ALUOP !== 2'b01) begin failures++;
                $display("FAIL beq_z%0d got=%0d/%b/%b exp=8/%b/01", z, state, pc_write,
                pc_src, z); end
            tick();
            checks++; if (state !== 4'd0) begin failures++;
                $display("FAIL beq_ret_z%0d got=%0d exp=0", z, state); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump_addi();
        opcode = 4'b0101; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state !== 4'd9 || {pc_write, pc_src} !== 3'b110) begin failures++;
            $display("FAIL jump got=%0d/%b exp=9/110", state, {pc_write, pc_src}); end
        tick();
        opcode = 4'b0100;
        tick(); tick();
        checks++; if (state !== 4'd10 || {alu_src_a, alu_src_b, ALUOP} !== 5'b11000) begin
            failures++; $display("FAIL addi_ex got=%0d/%b exp=10/11000", state,
            {alu_src_a, alu_src_b, ALUOP}); end
        tick();
        checks++; if (state !== 4'd11 || {reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
            failures++; $display("FAIL addi_wb got=%0d/%b exp=11/100", state,
            {reg_write, reg_dst, mem_to_reg}); end
        tick();
        checks++; if (state !== 4'd0 || instr_count !== 4'd6) begin failures++;
            $display("FAIL addi_done got=%0d/%0d exp=0/6", state, instr_count); end
    endtask

    task automatic test_illegal();
        opcode = 4'b0111; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state !== 4'd13 || {illegal, halted} !== 2'b10) begin failures++;
            $display("FAIL illegal_enter got=%0d/%b exp=13/10", state, {illegal, halted}); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (state !== 4'd13 || ctrl !== 15'd0 || illegal !== 1'b1) begin
                failures++; $display("FAIL illegal_hold%0d got=%0d/%h exp=13/0", i, state,
                ctrl); end
        end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        checks++; if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 4'd0) begin
            failures++; $display("FAIL illegal_reset got=%0d/%b/%0d exp=0/0/0", state,
            illegal, instr_count); end
    endtask

    task automatic test_halt();
        opcode = 4'b1111; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state !== 4'd12 || {halted, illegal} !== 2'b10 || ctrl !== 15'd0) begin
            failures++; $display("FAIL halt got=%0d/%b exp=12/10", state, {halted, illegal});
        end
        tick(); tick();
        checks++; if (state !== 4'd12 || halted !== 1'b1) begin failures++;
            $display("FAIL halt_sticky got=%0d exp=12", state); end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        checks++; if (state !== 4'd0 || halted !== 1'b0) begin failures++;
            $display("FAIL halt_reset got=%0d/%b exp=0/0", state, halted); end
    endtask

    task automatic test_sw_reset();
        opcode = 4'b0010; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd5 || {mem_write, iord, mem_read} !== 3'b110) begin
            failures++; $display("FAIL sw_wr got=%0d/%b exp=5/110", state,
            {mem_write, iord, mem_read}); end
        tick();
        checks++; if (state !== 4'd5) begin failures++;
            $display("FAIL sw_stall got=%0d exp=5", state); end
        rst = 1'b1; #1;
        checks++; if (mem_write !== 1'b0 || ctrl !== 15'd0) begin failures++;
            $display("FAIL sw_rst_strobe got=%b exp=0", mem_write); end
        tick();
        checks++; if (state !== 4'd0 || mem_write !== 1'b0 || instr_count !== 4'd0) begin
            failures++; $display("FAIL sw_rst_state got=%0d/%0d exp=0/0", state, instr_count);
        end
        rst = 1'b0; #1;
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] exp_cnt;
        opcode = 4'b0101; mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(); tick(); tick();
            exp_cnt = CNT_W'(i + 1);
            checks++; if (instr_count !== exp_cnt || state !== 4'd0) begin failures++;
                $display("FAIL wrap%0d got=%0d exp=%0d", i, instr_count, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_jump_addi();
        test_illegal();
        test_halt();
        test_sw_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
